// File: rtl/quo_rem_bcd_display_if.sv
// Result bus between the divider-side producer and the BCD/7-segment display block.
// The producer pushes quo/rem with a one-cycle in_valid strobe; the display block
// reports status and drives the converted digits and segment patterns.
interface quo_rem_bcd_display_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             busy;
   logic             out_valid;
   logic             dropped;
   logic [11:0]      quo_bcd;
   logic [11:0]      rem_bcd;
   logic [6:0]       hex5;
   logic [6:0]       hex4;
   logic [6:0]       hex3;
   logic [6:0]       hex2;
   logic [6:0]       hex1;
   logic [6:0]       hex0;

   modport master (
      output in_valid, quo, rem,
      input  busy, out_valid, dropped, quo_bcd, rem_bcd,
      input  hex5, hex4, hex3, hex2, hex1, hex0
   );

   modport slave (
      input  in_valid, quo, rem,
      output busy, out_valid, dropped, quo_bcd, rem_bcd,
      output hex5, hex4, hex3, hex2, hex1, hex0
   );
endinterface

// File: rtl/quo_rem_bcd_display.sv
// Quotient/remainder to BCD and 7-segment display driver.
// Each result is converted with a bit-serial double-dabble engine (quotient first,
// then remainder), then latched onto six digits: quotient on hex5..hex3, remainder
// on hex2..hex0. A one-deep pending slot holds a result that arrives mid-conversion.
module quo_rem_bcd_display #(
   parameter int WIDTH          = 8,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int BLANK_LZ       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   quo_rem_bcd_display_if.slave          bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV_Q = 2'd1, CONV_R = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0] LAST_BIT  = 4'(WIDTH - 1);
   localparam logic [6:0] BLANK_PAT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   state_t           state_r, state_s;
   logic [3:0]       cnt_r;
   logic [WIDTH-1:0] qbin_r, rbin_r;
   logic [11:0]      qbcd_r, rbcd_r;
   logic [WIDTH-1:0] pend_q_r, pend_r_r;
   logic             pend_flag_r;
   logic             dropped_r;
   logic             out_valid_r;
   logic [11:0]      quo_bcd_r, rem_bcd_r;
   logic [6:0]       hex_r [6];
   logic [6:0]       hex_s [6];
   logic             start_s, take_pend_s, pend_wr_s;
   logic [11:0]      qadj_s, radj_s;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
   function automatic logic [11:0] dd_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int n = 0; n < 3; n++) begin
         if (r[n*4 +: 4] >= 4'd5) begin
            r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
         end else begin
            r[n*4 +: 4] = r[n*4 +: 4];
         end
      end
      return r;
   endfunction

   // Segment pattern {g,f,e,d,c,b,a} for one decimal digit, in the configured polarity.
   function automatic logic [6:0] seg_encode(input logic [3:0] d, input logic blank);
      logic [6:0] lo;
      case (d)
         4'd0:    lo = 7'h40;
         4'd1:    lo = 7'h79;
         4'd2:    lo = 7'h24;
         4'd3:    lo = 7'h30;
         4'd4:    lo = 7'h19;
         4'd5:    lo = 7'h12;
         4'd6:    lo = 7'h02;
         4'd7:    lo = 7'h78;
         4'd8:    lo = 7'h00;
         4'd9:    lo = 7'h10;
         default: lo = 7'h7F;
      endcase
      if (blank) begin
         return BLANK_PAT;
      end else if (SEG_ACTIVE_LOW != 0) begin
         return lo;
      end else begin
         return ~lo;
      end
   endfunction

   // Three-digit group with optional leading-zero blanking; units always shown.
   function automatic logic [20:0] seg_group(input logic [11:0] b);
      logic blank_h, blank_t;
      blank_h = (BLANK_LZ != 0) && (b[11:8] == 4'd0);
      blank_t = blank_h && (b[7:4] == 4'd0);
      return {seg_encode(b[11:8], blank_h), seg_encode(b[7:4], blank_t), seg_encode(b[3:0], 1'b0)};
   endfunction

   // Next-state logic and job-start decision; pending slot has priority over a new strobe.
   always_comb begin
      state_s     = state_r;
      start_s     = 1'b0;
      take_pend_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (pend_flag_r) begin
               start_s     = 1'b1;
               take_pend_s = 1'b1;
               state_s     = CONV_Q;
            end else if (bus.in_valid) begin
               start_s = 1'b1;
               state_s = CONV_Q;
            end else begin
               state_s = IDLE;
            end
         end
         CONV_Q: begin
            if (cnt_r == LAST_BIT) state_s = CONV_R;
            else                   state_s = CONV_Q;
         end
         CONV_R: begin
            if (cnt_r == LAST_BIT) state_s = DONE;
            else                   state_s = CONV_R;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
      // A strobe goes to the pending slot unless it is starting a job directly.
      pend_wr_s = bus.in_valid && ((state_r != IDLE) || pend_flag_r);
   end

   // Segment patterns for both groups from the finished BCD accumulators.
   always_comb begin
      qadj_s = dd_adjust(qbcd_r);
      radj_s = dd_adjust(rbcd_r);
      {hex_s[5], hex_s[4], hex_s[3]} = seg_group(qbcd_r);
      {hex_s[2], hex_s[1], hex_s[0]} = seg_group(rbcd_r);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Pending slot: latest strobe wins; overwriting a held entry while busy is sticky-flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q_r    <= '0;
         pend_r_r    <= '0;
         pend_flag_r <= 1'b0;
         dropped_r   <= 1'b0;
      end else if (pend_wr_s) begin
         pend_q_r    <= bus.quo;
         pend_r_r    <= bus.rem;
         pend_flag_r <= 1'b1;
         if ((state_r != IDLE) && pend_flag_r) dropped_r <= 1'b1;
      end else if (take_pend_s) begin
         pend_flag_r <= 1'b0;
      end
   end

   // Double-dabble engine: operand latch on start, then one bit per edge per operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= 4'd0;
         qbin_r <= '0;
         rbin_r <= '0;
         qbcd_r <= 12'd0;
         rbcd_r <= 12'd0;
      end else if (start_s) begin
         cnt_r  <= 4'd0;
         qbin_r <= take_pend_s ? pend_q_r : bus.quo;
         rbin_r <= take_pend_s ? pend_r_r : bus.rem;
         qbcd_r <= 12'd0;
         rbcd_r <= 12'd0;
      end else if (state_r == CONV_Q) begin
         cnt_r  <= (cnt_r == LAST_BIT) ? 4'd0 : cnt_r + 4'd1;
         qbcd_r <= {qadj_s[10:0], qbin_r[WIDTH-1]};
         qbin_r <= {qbin_r[WIDTH-2:0], 1'b0};
      end else if (state_r == CONV_R) begin
         cnt_r  <= (cnt_r == LAST_BIT) ? 4'd0 : cnt_r + 4'd1;
         rbcd_r <= {radj_s[10:0], rbin_r[WIDTH-1]};
         rbin_r <= {rbin_r[WIDTH-2:0], 1'b0};
      end
   end

   // Output registers: update and pulse out_valid only on the DONE edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         quo_bcd_r   <= 12'd0;
         rem_bcd_r   <= 12'd0;
         for (int i = 0; i < 6; i++) hex_r[i] <= BLANK_PAT;
      end else begin
         out_valid_r <= (state_r == DONE);
         if (state_r == DONE) begin
            quo_bcd_r <= qbcd_r;
            rem_bcd_r <= rbcd_r;
            for (int i = 0; i < 6; i++) hex_r[i] <= hex_s[i];
         end
      end
   end

   assign bus.busy      = (state_r != IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.dropped   = dropped_r;
   assign bus.quo_bcd   = quo_bcd_r;
   assign bus.rem_bcd   = rem_bcd_r;
   assign bus.hex5      = hex_r[5];
   assign bus.hex4      = hex_r[4];
   assign bus.hex3      = hex_r[3];
   assign bus.hex2      = hex_r[2];
   assign bus.hex1      = hex_r[1];
   assign bus.hex0      = hex_r[0];

endmodule
